// File: rtl/kalman_filter.sv
// kalman_filter: per-harmonic two-state Kalman filters over several input series, coefficients from Mem1, states streamed to Mem2.
module kalman_filter #(
    parameter int DEBUG         = 1,
    parameter int HARMONICS_NUM = 26,
    parameter int IN_SERIES_NUM = 6,
    parameter int MEM1_AW       = 9
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [31:0]        Mem1_data_i,
    input  logic [MEM1_AW-1:0] Mem1_addrw_i,
    input  logic               Mem1_clk_w,
    input  logic               Mem1_clk_en_w,
    input  logic               Mem1_we_i,
    input  logic               enable_i,
    output logic [8:0]         Mem2_addrw_o,
    output logic               Mem2_we_o,
    output logic [35:0]        Mem2_data_o,
    output logic               WIP_flag_o,
    input  logic [53:0]        CIN,
    input  logic               SIGNEDCIN,
    output logic [53:0]        CO,
    output logic               SIGNEDCO
);
    localparam int SW = IN_SERIES_NUM > 1 ? $clog2(IN_SERIES_NUM) : 1;
    localparam int HW = HARMONICS_NUM > 1 ? $clog2(HARMONICS_NUM) : 1;

    typedef enum logic [1:0] {IDLE, PRED, ERR, UPD} state_t;

    state_t             state;
    logic signed [17:0] mem [2**MEM1_AW];
    logic signed [17:0] x1 [IN_SERIES_NUM][HARMONICS_NUM];
    logic signed [17:0] x2 [IN_SERIES_NUM][HARMONICS_NUM];
    logic signed [17:0] xp1 [HARMONICS_NUM];
    logic signed [17:0] xp2 [HARMONICS_NUM];
    logic [SW-1:0]      s_idx;
    logic [HW-1:0]      h_idx;
    logic [MEM1_AW-1:0] cb;
    logic signed [53:0] acc, ycin;
    logic signed [17:0] c, sn, k1, k2, u, x1c, x2c, x1p, x2p, x1n, x2n, e_n, e_r;
    logic signed [35:0] p_cx1, p_sx2, p_sx1, p_cx2, p_k1, p_k2;
    logic               en_q, start, h_last, s_last, unused_hi;

    function automatic logic signed [17:0] sat18(input logic signed [55:0] v);
        return v > 56'sd131071 ? 18'sh1FFFF : v < -56'sd131072 ? 18'sh20000 : v[17:0];
    endfunction

    assign unused_hi = ^Mem1_data_i[31:18];

    always_ff @(posedge clk_i)
        if (Mem1_clk_w && Mem1_clk_en_w && Mem1_we_i) mem[Mem1_addrw_i] <= Mem1_data_i[17:0];

    // Harmonic h owns the four words 16+4h .. 16+4h+3: cos, sin, K1, K2
    assign cb    = MEM1_AW'(16) + MEM1_AW'({h_idx, 2'b00});
    assign c     = mem[cb];
    assign sn    = mem[cb + MEM1_AW'(1)];
    assign k1    = mem[cb + MEM1_AW'(2)];
    assign k2    = mem[cb + MEM1_AW'(3)];
    assign u     = mem[MEM1_AW'(s_idx)];
    assign x1c   = x1[s_idx][h_idx];
    assign x2c   = x2[s_idx][h_idx];
    assign p_cx1 = 36'(c) * 36'(x1c);
    assign p_sx2 = 36'(sn) * 36'(x2c);
    assign p_sx1 = 36'(sn) * 36'(x1c);
    assign p_cx2 = 36'(c) * 36'(x2c);
    assign p_k1  = 36'(k1) * 36'(e_r);
    assign p_k2  = 36'(k2) * 36'(e_r);
    assign x1p   = sat18((56'(p_cx1) - 56'(p_sx2)) >>> 16);
    assign x2p   = sat18((56'(p_sx1) + 56'(p_cx2)) >>> 16);
    assign x1n   = sat18(56'(xp1[h_idx]) + (56'(p_k1) >>> 16));
    assign x2n   = sat18(56'(xp2[h_idx]) + (56'(p_k2) >>> 16));
    assign ycin  = acc + $signed(CIN);
    assign e_n   = sat18(56'(u) - 56'(ycin));
    assign start = state == IDLE && enable_i && !en_q;
    assign h_last = h_idx == HW'(HARMONICS_NUM - 1);
    assign s_last = s_idx == SW'(IN_SERIES_NUM - 1);

    // en_q resets high so enable_i must be seen low after reset before a run can start
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            en_q         <= 1'b1;
            s_idx        <= '0;
            h_idx        <= '0;
            acc          <= '0;
            e_r          <= '0;
            WIP_flag_o   <= 1'b0;
            Mem2_we_o    <= 1'b0;
            Mem2_addrw_o <= '0;
            Mem2_data_o  <= '0;
            CO           <= '0;
            SIGNEDCO     <= 1'b0;
            for (int i = 0; i < IN_SERIES_NUM; i++)
                for (int j = 0; j < HARMONICS_NUM; j++) begin
                    x1[i][j] <= '0;
                    x2[i][j] <= '0;
                end
            for (int j = 0; j < HARMONICS_NUM; j++) begin
                xp1[j] <= '0;
                xp2[j] <= '0;
            end
        end else begin
            en_q      <= enable_i;
            SIGNEDCO  <= SIGNEDCIN;
            Mem2_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    WIP_flag_o <= start;
                    state      <= start ? PRED : IDLE;
                end
                PRED: begin
                    xp1[h_idx] <= x1p;
                    xp2[h_idx] <= x2p;
                    acc        <= (h_idx == '0 ? '0 : acc) + 54'(x1p);
                    h_idx      <= h_last ? '0 : h_idx + HW'(1);
                    state      <= h_last ? ERR : PRED;
                end
                ERR: begin
                    acc   <= ycin;
                    e_r   <= e_n;
                    state <= UPD;
                end
                UPD: begin
                    x1[s_idx][h_idx] <= x1n;
                    x2[s_idx][h_idx] <= x2n;
                    Mem2_we_o        <= 1'b1;
                    Mem2_addrw_o     <= {4'(s_idx), 5'(h_idx)};
                    Mem2_data_o      <= {x2n, x1n};
                    h_idx            <= h_last ? '0 : h_idx + HW'(1);
                    if (h_last) begin
                        s_idx <= s_last ? '0 : s_idx + SW'(1);
                        state <= s_last ? IDLE : PRED;
                        if (DEBUG != 0 && s_last) CO <= acc;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kalman_filter.sv
// tb_kalman_filter: randomized and directed scenarios checked against a behavioural model of the filter bank.
module tb_kalman_filter;
    localparam int H = 26, S = 6, AW = 9, BOUND = 3*H*S + 8*S + 8, NW = 16 + 4*H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni, Mem1_clk_w, Mem1_clk_en_w, Mem1_we_i, enable_i, SIGNEDCIN, SIGNEDCO;
    logic [31:0]   Mem1_data_i;
    logic [AW-1:0] Mem1_addrw_i;
    logic [8:0]    Mem2_addrw_o;
    logic          Mem2_we_o, WIP_flag_o;
    logic [35:0]   Mem2_data_o;
    logic [53:0]   CIN, CO;

    kalman_filter #(.DEBUG(1), .HARMONICS_NUM(H), .IN_SERIES_NUM(S), .MEM1_AW(AW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .Mem1_data_i(Mem1_data_i), .Mem1_addrw_i(Mem1_addrw_i),
        .Mem1_clk_w(Mem1_clk_w), .Mem1_clk_en_w(Mem1_clk_en_w), .Mem1_we_i(Mem1_we_i),
        .enable_i(enable_i), .Mem2_addrw_o(Mem2_addrw_o), .Mem2_we_o(Mem2_we_o),
        .Mem2_data_o(Mem2_data_o), .WIP_flag_o(WIP_flag_o), .CIN(CIN), .SIGNEDCIN(SIGNEDCIN),
        .CO(CO), .SIGNEDCO(SIGNEDCO)
    );

    int          n_checks = 0, n_fail = 0;
    int          m [NW];
    int          mx1 [S][H], mx2 [S][H];
    logic [44:0] got_q [$], exp_q [$];
    longint      exp_co;

    always @(negedge clk) if (Mem2_we_o === 1'b1) got_q.push_back({Mem2_addrw_o, Mem2_data_o});

    function automatic int sat(input longint v);
        return v > 131071 ? 131071 : (v < -131072 ? -131072 : int'(v));
    endfunction

    function automatic void model_zero();
        for (int s = 0; s < S; s++) for (int h = 0; h < H; h++) begin mx1[s][h] = 0; mx2[s][h] = 0; end
    endfunction

    function automatic void model_run();
        longint y;
        int p1 [H], p2 [H], e;
        exp_q.delete();
        for (int s = 0; s < S; s++) begin
            y = 0;
            for (int h = 0; h < H; h++) begin
                p1[h] = sat((longint'(m[16+4*h]) * mx1[s][h] - longint'(m[17+4*h]) * mx2[s][h]) >>> 16);
                p2[h] = sat((longint'(m[17+4*h]) * mx1[s][h] + longint'(m[16+4*h]) * mx2[s][h]) >>> 16);
                y += p1[h];
            end
            y = ((y + longint'($signed(CIN))) <<< 10) >>> 10;
            e = sat(m[s] - y);
            for (int h = 0; h < H; h++) begin
                mx1[s][h] = sat(p1[h] + ((longint'(m[18+4*h]) * e) >>> 16));
                mx2[s][h] = sat(p2[h] + ((longint'(m[19+4*h]) * e) >>> 16));
                exp_q.push_back({9'(s*32 + h), 18'(mx2[s][h]), 18'(mx1[s][h])});
            end
            exp_co = y;
        end
    endfunction

    task automatic mem_write(input int a, input logic [31:0] d, input logic [2:0] st);
        @(negedge clk);
        Mem1_addrw_i = AW'(a);
        Mem1_data_i  = d;
        {Mem1_clk_w, Mem1_clk_en_w, Mem1_we_i} = st;
        @(negedge clk);
        {Mem1_clk_w, Mem1_clk_en_w, Mem1_we_i} = 3'b000;
        if (st == 3'b111) m[a] = int'($signed(d[17:0]));
    endtask

    task automatic clear_mem(input int u_val);
        for (int a = 0; a < NW; a++) mem_write(a, {14'($urandom), 18'(a < S ? u_val : 0)}, 3'b111);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        model_zero();
    endtask

    // kind 1: drop and re-raise enable_i mid-run; kind 2: rewrite u of the last series mid-run
    task automatic do_run(input int act_at, input int kind, output int cyc, output bit rose, output bit fell_ok);
        bit prev_we;
        got_q.delete();
        @(negedge clk) enable_i = 1'b0;
        @(negedge clk) enable_i = 1'b1;
        @(negedge clk);
        rose = WIP_flag_o;
        cyc = 0;
        prev_we = 1'b0;
        while (WIP_flag_o === 1'b1 && cyc < BOUND) begin
            prev_we = Mem2_we_o;
            if (cyc == act_at && kind == 1) enable_i = 1'b0;
            if (cyc == act_at && kind == 2) begin
                Mem1_addrw_i = AW'(S-1);
                Mem1_data_i  = 32'hABC0_2345;
                {Mem1_clk_w, Mem1_clk_en_w, Mem1_we_i} = 3'b111;
                m[S-1] = 'h2345;
            end
            if (cyc == act_at + 1) begin
                enable_i = 1'b1;
                {Mem1_clk_w, Mem1_clk_en_w, Mem1_we_i} = 3'b000;
            end
            @(negedge clk);
            cyc++;
        end
        fell_ok = WIP_flag_o === 1'b0 && prev_we;
    endtask

    task automatic test_reset();
        bit wip_seen;
        SIGNEDCIN = 1'b1;
        @(negedge clk) rst_ni = 1'b1;
        @(negedge clk) rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (WIP_flag_o !== 1'b0) begin n_fail++; $display("FAIL reset_wip: got %b expected 0", WIP_flag_o); end
        n_checks++; if (Mem2_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", Mem2_we_o); end
        n_checks++; if (Mem2_addrw_o !== 9'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", Mem2_addrw_o); end
        n_checks++; if (Mem2_data_o !== 36'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", Mem2_data_o); end
        n_checks++; if (CO !== 54'd0) begin n_fail++; $display("FAIL reset_co: got %h expected 0", CO); end
        n_checks++; if (SIGNEDCO !== 1'b0) begin n_fail++; $display("FAIL reset_signedco: got %b expected 0", SIGNEDCO); end
        rst_ni = 1'b1;
        model_zero();
        got_q.delete();
        wip_seen = 1'b0;
        repeat (10) begin @(negedge clk); wip_seen |= WIP_flag_o; end
        n_checks++; if (wip_seen || got_q.size() != 0) begin n_fail++; $display("FAIL reset_no_start: got wip %b pulses %0d expected 0 0", wip_seen, got_q.size()); end
        n_checks++; if (SIGNEDCO !== 1'b1) begin n_fail++; $display("FAIL reset_signedco_follow: got %b expected 1", SIGNEDCO); end
        SIGNEDCIN = 1'b0;
    endtask

    task automatic test_zero_coeffs();
        int cyc; bit rose, fell; bit wip_seen;
        do_run(-10, 0, cyc, rose, fell);
        model_run();
        n_checks++; if (!rose || !fell) begin n_fail++; $display("FAIL zero_wip: got rose %b fell %b cycles %0d expected 1 1 within %0d", rose, fell, cyc, BOUND); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL zero_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero_pulse[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        wip_seen = 1'b0;
        repeat (20) begin @(negedge clk); wip_seen |= WIP_flag_o; end
        n_checks++; if (wip_seen) begin n_fail++; $display("FAIL zero_held_enable: got wip 1 expected 0"); end
    endtask

    task automatic test_harmonic0();
        int cyc; bit rose, fell;
        do_reset();
        clear_mem(0);
        mem_write(0, 32'd1000, 3'b111);
        mem_write(16, 32'd65536, 3'b111);
        mem_write(18, 32'd32768, 3'b111);
        for (int r = 0; r < 2; r++) begin
            do_run(-10, 0, cyc, rose, fell);
            model_run();
            n_checks++; if (got_q.size() == 0 || got_q[0] !== {9'd0, 18'd0, 18'(r == 0 ? 500 : 750)})
                begin n_fail++; $display("FAIL h0_run%0d: got %h expected x1 %0d", r, got_q.size() ? got_q[0] : 45'h0, r == 0 ? 500 : 750); end
            n_checks++; if (got_q.size() != exp_q.size() || !fell) begin n_fail++; $display("FAIL h0_count%0d: got %0d fell %b expected %0d", r, got_q.size(), fell, exp_q.size()); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL h0_pulse[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_saturation();
        int cyc; bit rose, fell;
        do_reset();
        clear_mem(0);
        mem_write(0, 32'd131071, 3'b111);
        mem_write(16, 32'd65536, 3'b111);
        mem_write(18, 32'd131071, 3'b111);
        do_run(-10, 0, cyc, rose, fell);
        model_run();
        n_checks++; if (got_q.size() == 0 || got_q[0][35:0] !== {18'd0, 18'h1FFFF}) begin n_fail++; $display("FAIL sat_x1: got %h expected %h", got_q.size() ? got_q[0][35:0] : 36'h0, {18'd0, 18'h1FFFF}); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sat_pulse[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_cin();
        int cyc; bit rose, fell;
        do_reset();
        clear_mem(0);
        mem_write(18, 32'd65536, 3'b111);
        CIN = 54'd100;
        do_run(-10, 0, cyc, rose, fell);
        model_run();
        n_checks++; if (got_q.size() == 0 || got_q[0][17:0] !== 18'h3FF9C) begin n_fail++; $display("FAIL cin_x1: got %h expected 3ff9c", got_q.size() ? got_q[0][17:0] : 18'h0); end
        n_checks++; if (CO !== 54'd100) begin n_fail++; $display("FAIL cin_co: got %0d expected 100", CO); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL cin_pulse[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        CIN = '0;
    endtask

    task automatic test_random();
        int cyc; bit rose, fell;
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < NW; a++)
                mem_write(a, a < 16 ? $urandom : {14'($urandom), 18'(int'($urandom_range(131071, 0)) - 65536)}, 3'b111);
            mem_write(0, $urandom, 3'(1 << (r % 3)) ^ 3'b111);
            CIN = 54'(longint'($urandom_range(4000, 0)) - 2000);
            do_run(-10, 0, cyc, rose, fell);
            model_run();
            n_checks++; if (got_q.size() != exp_q.size() || !fell) begin n_fail++; $display("FAIL rand%0d_count: got %0d fell %b expected %0d", r, got_q.size(), fell, exp_q.size()); end
            n_checks++; if (CO !== 54'(exp_co)) begin n_fail++; $display("FAIL rand%0d_co: got %h expected %h", r, CO, 54'(exp_co)); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_pulse[%0d]: got %h expected %h", r, i, got_q[i], exp_q[i]); end
            end
        end
        CIN = '0;
    endtask

    task automatic test_back_to_back();
        int cyc; bit rose, fell, wip_seen;
        do_run(50, 1, cyc, rose, fell);
        model_run();
        n_checks++; if (got_q.size() != S*H || !fell) begin n_fail++; $display("FAIL b2b_count: got %0d fell %b expected %0d", got_q.size(), fell, S*H); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_pulse[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        wip_seen = 1'b0;
        repeat (20) begin @(negedge clk); wip_seen |= WIP_flag_o; end
        n_checks++; if (wip_seen) begin n_fail++; $display("FAIL b2b_second_run: got wip 1 expected 0"); end
    endtask

    task automatic test_midrun_write();
        int cyc; bit rose, fell;
        do_run(5, 2, cyc, rose, fell);
        model_run();
        n_checks++; if (got_q.size() != exp_q.size() || !fell) begin n_fail++; $display("FAIL mw_count: got %0d fell %b expected %0d", got_q.size(), fell, exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mw_pulse[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midrun();
        int n, cyc; bit rose, fell;
        got_q.delete();
        @(negedge clk) enable_i = 1'b0;
        @(negedge clk) enable_i = 1'b1;
        repeat (100) @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        n = got_q.size();
        n_checks++; if (WIP_flag_o !== 1'b0 || Mem2_we_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stop: got wip %b we %b expected 0 0", WIP_flag_o, Mem2_we_o); end
        n_checks++; if (n == 0 || n >= S*H) begin n_fail++; $display("FAIL rstmid_partial: got %0d pulses expected between 1 and %0d", n, S*H - 1); end
        repeat (4) @(negedge clk);
        rst_ni = 1'b1;
        model_zero();
        repeat (10) @(negedge clk);
        n_checks++; if (got_q.size() != n || WIP_flag_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d pulses wip %b expected %0d 0", got_q.size(), WIP_flag_o, n); end
        do_run(-10, 0, cyc, rose, fell);
        model_run();
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_pulse[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_signedco();
        logic prev;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) SIGNEDCIN = 1'($urandom);
            prev = SIGNEDCIN;
            @(negedge clk);
            n_checks++; if (SIGNEDCO !== prev) begin n_fail++; $display("FAIL signedco[%0d]: got %b expected %b", i, SIGNEDCO, prev); end
        end
    endtask

    initial begin
        rst_ni = 1'b0; enable_i = 1'b1; SIGNEDCIN = 1'b0; CIN = '0;
        Mem1_clk_w = 1'b0; Mem1_clk_en_w = 1'b0; Mem1_we_i = 1'b0; Mem1_data_i = '0; Mem1_addrw_i = '0;
        clear_mem(1000);
        test_reset();
        test_zero_coeffs();
        test_harmonic0();
        test_saturation();
        test_cin();
        test_random();
        test_back_to_back();
        test_midrun_write();
        test_reset_midrun();
        test_signedco();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
